// File: rtl/rv_id_ex_if.sv
// Signal bundle between the ID/hazard/forwarding side and the ID/EX stage.
// The stage consumes the slave modport; whoever feeds the stage uses master.
interface rv_id_ex_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RAW  = 5
);
  // Pipeline control
  logic            stall_i;
  logic            flush_i;

  // Decoded instruction from ID
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic [XLEN-1:0] id_imm_i;
  logic [RAW-1:0]  id_rs1_addr_i;
  logic [RAW-1:0]  id_rs2_addr_i;
  logic [RAW-1:0]  id_rd_addr_i;
  logic [3:0]      id_alu_op_i;
  logic [1:0]      id_op1_sel_i;
  logic [1:0]      id_op2_sel_i;
  logic            id_reg_we_i;
  logic            id_mem_rd_i;
  logic            id_mem_wr_i;

  // Forwarding sources
  logic            exm_we_i;
  logic [RAW-1:0]  exm_rd_i;
  logic [XLEN-1:0] exm_data_i;
  logic            mwb_we_i;
  logic [RAW-1:0]  mwb_rd_i;
  logic [XLEN-1:0] mwb_data_i;

  // Stage outputs towards the ALU and downstream stages
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [3:0]      alu_op_o;
  logic [XLEN-1:0] ex_store_data_o;
  logic [RAW-1:0]  ex_rd_o;
  logic            ex_reg_we_o;
  logic            ex_mem_rd_o;
  logic            ex_mem_wr_o;
  logic            ld_use_o;

  modport master (
    output stall_i, flush_i,
    output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_alu_op_i,
    output id_op1_sel_i, id_op2_sel_i, id_reg_we_i, id_mem_rd_i, id_mem_wr_i,
    output exm_we_i, exm_rd_i, exm_data_i, mwb_we_i, mwb_rd_i, mwb_data_i,
    input  ex_valid_o, ex_pc_o, op1_o, op2_o, alu_op_o, ex_store_data_o,
    input  ex_rd_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, ld_use_o
  );

  modport slave (
    input  stall_i, flush_i,
    input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_alu_op_i,
    input  id_op1_sel_i, id_op2_sel_i, id_reg_we_i, id_mem_rd_i, id_mem_wr_i,
    input  exm_we_i, exm_rd_i, exm_data_i, mwb_we_i, mwb_rd_i, mwb_data_i,
    output ex_valid_o, ex_pc_o, op1_o, op2_o, alu_op_o, ex_store_data_o,
    output ex_rd_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, ld_use_o
  );
endinterface

// File: rtl/rv_id_ex.sv
// ID/EX pipeline register for the RV64 core: captures decoded fields,
// forwards operands from EX/MEM and MEM/WB, builds ALU operands and
// reports load-use hazards against the instruction currently in ID.
module rv_id_ex #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RAW  = 5
) (
  input logic         clk_i,
  input logic         rst_n_i,
  rv_id_ex_if.slave   bus
);

  typedef enum logic [1:0] {
    OP1_RS1   = 2'd0,
    OP1_PC    = 2'd1,
    OP1_ZERO  = 2'd2,
    OP1_ZERO3 = 2'd3
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2   = 2'd0,
    OP2_IMM   = 2'd1,
    OP2_FOUR  = 2'd2,
    OP2_ZERO  = 2'd3
  } op2_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [RAW-1:0]  rd_addr;
    logic [3:0]      alu_op;
    op1_sel_e        op1_sel;
    op2_sel_e        op2_sel;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
  } stage_t;

  stage_t          st;
  stage_t          cap;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Forwarding source selection for one operand; EX/MEM wins over MEM/WB,
  // and x0 never matches so a zero read stays zero.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RAW-1:0]  addr,
    input logic [XLEN-1:0] rf_data,
    input logic            exm_we,
    input logic [RAW-1:0]  exm_rd,
    input logic [XLEN-1:0] exm_data,
    input logic            mwb_we,
    input logic [RAW-1:0]  mwb_rd,
    input logic [XLEN-1:0] mwb_data
  );
    logic [XLEN-1:0] res;
    res = rf_data;
    if (exm_we && (exm_rd == addr) && (addr != '0)) begin
      res = exm_data;
    end else if (mwb_we && (mwb_rd == addr) && (addr != '0)) begin
      res = mwb_data;
    end
    return res;
  endfunction

  // Build the entry that would be captured this edge; an invalid ID slot or a
  // flush turns it into a bubble by clearing valid and all side-effect flags.
  always_comb begin
    cap          = '0;
    cap.pc       = bus.id_pc_i;
    cap.rs1_data = bus.id_rs1_data_i;
    cap.rs2_data = bus.id_rs2_data_i;
    cap.imm      = bus.id_imm_i;
    cap.rs1_addr = bus.id_rs1_addr_i;
    cap.rs2_addr = bus.id_rs2_addr_i;
    cap.rd_addr  = bus.id_rd_addr_i;
    cap.alu_op   = bus.id_alu_op_i;
    cap.op1_sel  = op1_sel_e'(bus.id_op1_sel_i);
    cap.op2_sel  = op2_sel_e'(bus.id_op2_sel_i);
    if (bus.id_valid_i && !bus.flush_i) begin
      cap.valid  = 1'b1;
      cap.reg_we = bus.id_reg_we_i;
      cap.mem_rd = bus.id_mem_rd_i;
      cap.mem_wr = bus.id_mem_wr_i;
    end
  end

  // Stage register: flush beats stall, stall holds, otherwise capture ID.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st <= '0;
    end else if (bus.flush_i || !bus.stall_i) begin
      st <= cap;
    end
  end

  // Operand forwarding, re-evaluated every cycle including during stalls.
  always_comb begin
    rs1_fwd = fwd_sel(st.rs1_addr, st.rs1_data,
                      bus.exm_we_i, bus.exm_rd_i, bus.exm_data_i,
                      bus.mwb_we_i, bus.mwb_rd_i, bus.mwb_data_i);
    rs2_fwd = fwd_sel(st.rs2_addr, st.rs2_data,
                      bus.exm_we_i, bus.exm_rd_i, bus.exm_data_i,
                      bus.mwb_we_i, bus.mwb_rd_i, bus.mwb_data_i);
  end

  // ALU operand muxes driven by the registered select fields.
  always_comb begin
    bus.op1_o = '0;
    unique case (st.op1_sel)
      OP1_RS1:   bus.op1_o = rs1_fwd;
      OP1_PC:    bus.op1_o = st.pc;
      OP1_ZERO,
      OP1_ZERO3: bus.op1_o = '0;
      default:   bus.op1_o = '0;
    endcase

    bus.op2_o = '0;
    unique case (st.op2_sel)
      OP2_RS2:   bus.op2_o = rs2_fwd;
      OP2_IMM:   bus.op2_o = st.imm;
      OP2_FOUR:  bus.op2_o = XLEN'(4);
      OP2_ZERO:  bus.op2_o = '0;
      default:   bus.op2_o = '0;
    endcase
  end

  // Registered fields and valid-gated control towards EX and the hazard unit.
  always_comb begin
    bus.ex_valid_o      = st.valid;
    bus.ex_pc_o         = st.pc;
    bus.ex_rd_o         = st.rd_addr;
    bus.ex_store_data_o = rs2_fwd;
    bus.alu_op_o        = st.valid ? st.alu_op : 4'd0;
    bus.ex_reg_we_o     = st.valid & st.reg_we;
    bus.ex_mem_rd_o     = st.valid & st.mem_rd;
    bus.ex_mem_wr_o     = st.valid & st.mem_wr;
    bus.ld_use_o        = st.valid & st.mem_rd & (st.rd_addr != '0) &
                          ((st.rd_addr == bus.id_rs1_addr_i) |
                           (st.rd_addr == bus.id_rs2_addr_i));
  end

endmodule

// File: tb/tb_rv_id_ex.sv
// Directed bench for rv_id_ex: capture, forwarding priority, x0 handling,
// operand selects, load-use detection, stall/flush and async reset.
module tb_rv_id_ex;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RAW  = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rv_id_ex_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

  rv_id_ex #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Stimulus only: place one decoded instruction on the ID side.
  task automatic drive_id(
    input logic            valid,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] rs1d,
    input logic [XLEN-1:0] rs2d,
    input logic [XLEN-1:0] imm,
    input logic [RAW-1:0]  rs1a,
    input logic [RAW-1:0]  rs2a,
    input logic [RAW-1:0]  rd,
    input logic [3:0]      alu,
    input logic [1:0]      s1,
    input logic [1:0]      s2,
    input logic            we,
    input logic            mr,
    input logic            mw
  );
    bus.id_valid_i    = valid;
    bus.id_pc_i       = pc;
    bus.id_rs1_data_i = rs1d;
    bus.id_rs2_data_i = rs2d;
    bus.id_imm_i      = imm;
    bus.id_rs1_addr_i = rs1a;
    bus.id_rs2_addr_i = rs2a;
    bus.id_rd_addr_i  = rd;
    bus.id_alu_op_i   = alu;
    bus.id_op1_sel_i  = s1;
    bus.id_op2_sel_i  = s2;
    bus.id_reg_we_i   = we;
    bus.id_mem_rd_i   = mr;
    bus.id_mem_wr_i   = mw;
  endtask

  task automatic clear_fwd();
    bus.exm_we_i = 1'b0; bus.exm_rd_i = '0; bus.exm_data_i = '0;
    bus.mwb_we_i = 1'b0; bus.mwb_rd_i = '0; bus.mwb_data_i = '0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", bus.ex_valid_o); end
    total++; if (bus.op1_o !== 64'd0) begin bad++; $display("FAIL rst_op1 got=%0h exp=0", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd0) begin bad++; $display("FAIL rst_op2 got=%0h exp=0", bus.op2_o); end
    total++; if (bus.alu_op_o !== 4'd0) begin bad++; $display("FAIL rst_alu got=%0h exp=0", bus.alu_op_o); end
    total++; if (bus.ld_use_o !== 1'b0) begin bad++; $display("FAIL rst_lduse got=%0h exp=0", bus.ld_use_o); end
    // A valid ID instruction must not be captured while reset is held.
    drive_id(1'b1, 64'h80, 64'd9, 64'd9, 64'd9, 5'd1, 5'd2, 5'd3, 4'd2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%0h exp=0", bus.ex_valid_o); end
    total++; if (bus.ex_pc_o !== 64'd0) begin bad++; $display("FAIL rst_hold_pc got=%0h exp=0", bus.ex_pc_o); end
    total++; if (bus.ex_rd_o !== 5'd0) begin bad++; $display("FAIL rst_hold_rd got=%0h exp=0", bus.ex_rd_o); end
    @(negedge clk);
    drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    // addi x5, x1, 7 with x1 = 100
    @(negedge clk);
    drive_id(1'b1, 64'h1000, 64'd100, 64'd0, 64'd7, 5'd1, 5'd0, 5'd5, 4'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0h exp=1", bus.ex_valid_o); end
    total++; if (bus.op1_o !== 64'd100) begin bad++; $display("FAIL cap_op1 got=%0d exp=100", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd7) begin bad++; $display("FAIL cap_op2 got=%0d exp=7", bus.op2_o); end
    total++; if (bus.ex_rd_o !== 5'd5) begin bad++; $display("FAIL cap_rd got=%0d exp=5", bus.ex_rd_o); end
    total++; if (bus.ex_reg_we_o !== 1'b1) begin bad++; $display("FAIL cap_we got=%0h exp=1", bus.ex_reg_we_o); end
    total++; if (bus.ex_pc_o !== 64'h1000) begin bad++; $display("FAIL cap_pc got=%0h exp=1000", bus.ex_pc_o); end
    // Invalid ID slot becomes a bubble with flags cleared.
    @(negedge clk);
    bus.id_valid_i = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%0h exp=0", bus.ex_valid_o); end
    total++; if (bus.ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL bubble_we got=%0h exp=0", bus.ex_reg_we_o); end
  endtask

  task automatic test_forwarding();
    // add x3, x1, x2 with x1 = 10, x2 = 20
    @(negedge clk);
    drive_id(1'b1, 64'h1100, 64'd10, 64'd20, 64'd0, 5'd1, 5'd2, 5'd3, 4'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.exm_we_i = 1'b1; bus.exm_rd_i = 5'd1; bus.exm_data_i = 64'd55;
    bus.mwb_we_i = 1'b1; bus.mwb_rd_i = 5'd1; bus.mwb_data_i = 64'd77;
    #1;
    total++; if (bus.op1_o !== 64'd55) begin bad++; $display("FAIL fwd_exm_prio got=%0d exp=55", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd20) begin bad++; $display("FAIL fwd_rs2_nomatch got=%0d exp=20", bus.op2_o); end
    bus.exm_rd_i = 5'd2;
    #1;
    total++; if (bus.op1_o !== 64'd77) begin bad++; $display("FAIL fwd_mwb got=%0d exp=77", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd55) begin bad++; $display("FAIL fwd_rs2_exm got=%0d exp=55", bus.op2_o); end
    total++; if (bus.ex_store_data_o !== 64'd55) begin bad++; $display("FAIL fwd_store got=%0d exp=55", bus.ex_store_data_o); end
    // exm address matches rs2 but write-enable is off: MEM/WB supplies rs2.
    bus.exm_we_i = 1'b0; bus.mwb_rd_i = 5'd2;
    #1;
    total++; if (bus.op2_o !== 64'd77) begin bad++; $display("FAIL fwd_exm_we_gate got=%0d exp=77", bus.op2_o); end
    total++; if (bus.op1_o !== 64'd10) begin bad++; $display("FAIL fwd_rs1_rf got=%0d exp=10", bus.op1_o); end
    clear_fwd();
    #1;
    total++; if (bus.op1_o !== 64'd10) begin bad++; $display("FAIL fwd_none_op1 got=%0d exp=10", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd20) begin bad++; $display("FAIL fwd_none_op2 got=%0d exp=20", bus.op2_o); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive_id(1'b1, 64'h1200, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd6, 4'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.exm_we_i = 1'b1; bus.exm_rd_i = 5'd0; bus.exm_data_i = 64'd99;
    bus.mwb_we_i = 1'b1; bus.mwb_rd_i = 5'd0; bus.mwb_data_i = 64'd88;
    #1;
    total++; if (bus.op1_o !== 64'd0) begin bad++; $display("FAIL x0_op1 got=%0d exp=0", bus.op1_o); end
    total++; if (bus.ex_store_data_o !== 64'd0) begin bad++; $display("FAIL x0_store got=%0d exp=0", bus.ex_store_data_o); end
    clear_fwd();
  endtask

  task automatic test_op_sel();
    // op1 = pc, op2 = 4 (jal-style link computation), alu_op 5
    @(negedge clk);
    drive_id(1'b1, 64'h2000, 64'd33, 64'd44, 64'd12, 5'd1, 5'd2, 5'd1, 4'd5, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.op1_o !== 64'h2000) begin bad++; $display("FAIL sel_op1_pc got=%0h exp=2000", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd4) begin bad++; $display("FAIL sel_op2_four got=%0d exp=4", bus.op2_o); end
    total++; if (bus.alu_op_o !== 4'd5) begin bad++; $display("FAIL sel_alu got=%0d exp=5", bus.alu_op_o); end
    @(negedge clk);
    drive_id(1'b1, 64'h2004, 64'd33, 64'd44, 64'd12, 5'd1, 5'd2, 5'd1, 4'd5, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.op1_o !== 64'd0) begin bad++; $display("FAIL sel_op1_zero2 got=%0d exp=0", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd0) begin bad++; $display("FAIL sel_op2_zero got=%0d exp=0", bus.op2_o); end
    @(negedge clk);
    drive_id(1'b1, 64'h2008, 64'd33, 64'd44, 64'd12, 5'd1, 5'd2, 5'd1, 4'd5, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.op1_o !== 64'd0) begin bad++; $display("FAIL sel_op1_zero3 got=%0d exp=0", bus.op1_o); end
    total++; if (bus.op2_o !== 64'd44) begin bad++; $display("FAIL sel_op2_rs2 got=%0d exp=44", bus.op2_o); end
  endtask

  task automatic test_load_use();
    // ld x4, 0(x1)
    @(negedge clk);
    drive_id(1'b1, 64'h3000, 64'd0, 64'd0, 64'd0, 5'd1, 5'd0, 5'd4, 4'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    total++; if (bus.ex_mem_rd_o !== 1'b1) begin bad++; $display("FAIL lu_memrd got=%0h exp=1", bus.ex_mem_rd_o); end
    bus.id_rs1_addr_i = 5'd1; bus.id_rs2_addr_i = 5'd4;
    #1;
    total++; if (bus.ld_use_o !== 1'b1) begin bad++; $display("FAIL lu_rs2_hit got=%0h exp=1", bus.ld_use_o); end
    bus.id_rs2_addr_i = 5'd6;
    #1;
    total++; if (bus.ld_use_o !== 1'b0) begin bad++; $display("FAIL lu_miss got=%0h exp=0", bus.ld_use_o); end
    bus.id_rs1_addr_i = 5'd4; bus.id_valid_i = 1'b0;
    #1;
    total++; if (bus.ld_use_o !== 1'b1) begin bad++; $display("FAIL lu_rs1_hit_idinv got=%0h exp=1", bus.ld_use_o); end
    // ld x0: never a hazard.
    @(negedge clk);
    drive_id(1'b1, 64'h3004, 64'd0, 64'd0, 64'd0, 5'd1, 5'd0, 5'd0, 4'd0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.id_rs1_addr_i = 5'd0; bus.id_rs2_addr_i = 5'd0;
    #1;
    total++; if (bus.ld_use_o !== 1'b0) begin bad++; $display("FAIL lu_rd0 got=%0h exp=0", bus.ld_use_o); end
  endtask

  task automatic test_stall_flush();
    // Instruction A
    @(negedge clk);
    drive_id(1'b1, 64'h4000, 64'd11, 64'd0, 64'd22, 5'd1, 5'd0, 5'd7, 4'd3, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    // Instruction B waits in ID while the stage is stalled.
    @(negedge clk);
    bus.stall_i = 1'b1;
    drive_id(1'b1, 64'h5000, 64'd66, 64'd0, 64'd88, 5'd2, 5'd0, 5'd9, 4'd6, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (bus.ex_pc_o !== 64'h4000) begin bad++; $display("FAIL stall_pc c=%0d got=%0h exp=4000", c, bus.ex_pc_o); end
      total++; if (bus.alu_op_o !== 4'd3 || bus.ex_rd_o !== 5'd7) begin bad++; $display("FAIL stall_alu_rd c=%0d got=%0d/%0d exp=3/7", c, bus.alu_op_o, bus.ex_rd_o); end
      total++; if (bus.op1_o !== 64'd11 || bus.op2_o !== 64'd22) begin bad++; $display("FAIL stall_ops c=%0d got=%0d/%0d exp=11/22", c, bus.op1_o, bus.op2_o); end
    end
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h exp=0", bus.ex_valid_o); end
    total++; if (bus.ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL flush_we got=%0h exp=0", bus.ex_reg_we_o); end
    total++; if (bus.alu_op_o !== 4'd0) begin bad++; $display("FAIL flush_alu got=%0d exp=0", bus.alu_op_o); end
    @(negedge clk);
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 64'h5000) begin bad++; $display("FAIL resume got=%0h/%0h exp=1/5000", bus.ex_valid_o, bus.ex_pc_o); end
    total++; if (bus.alu_op_o !== 4'd6) begin bad++; $display("FAIL resume_alu got=%0d exp=6", bus.alu_op_o); end
  endtask

  task automatic test_async_reset();
    // sd x2, 8(x1)
    @(negedge clk);
    drive_id(1'b1, 64'h6000, 64'd5, 64'h55, 64'd8, 5'd1, 5'd2, 5'd0, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++; if (bus.ex_mem_wr_o !== 1'b1) begin bad++; $display("FAIL st_memwr got=%0h exp=1", bus.ex_mem_wr_o); end
    total++; if (bus.ex_store_data_o !== 64'h55) begin bad++; $display("FAIL st_data got=%0h exp=55", bus.ex_store_data_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0h exp=0", bus.ex_valid_o); end
    total++; if (bus.ex_mem_wr_o !== 1'b0) begin bad++; $display("FAIL arst_memwr got=%0h exp=0", bus.ex_mem_wr_o); end
    total++; if (bus.ex_store_data_o !== 64'd0) begin bad++; $display("FAIL arst_store got=%0h exp=0", bus.ex_store_data_o); end
    total++; if (bus.ex_pc_o !== 64'd0) begin bad++; $display("FAIL arst_pc got=%0h exp=0", bus.ex_pc_o); end
    @(negedge clk);
    drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%0h exp=0", bus.ex_valid_o); end
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    total = 0;
    bad   = 0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    clear_fwd();
    drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_capture();
    test_forwarding();
    test_x0();
    test_op_sel();
    test_load_use();
    test_stall_flush();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
